// File: rtl/p251_pkg.sv
// Shared GF(251) definitions for the SDitH field datapath (adder, multiplier, inverse).
package p251_pkg;

  localparam int P251  = 251;
  localparam int WIDTH = 8;

  typedef logic [WIDTH-1:0] fe_t;

endpackage

// File: rtl/p251_reduce.sv
// Combinational conditional subtract: maps 0..2P-1 onto 0..P-1.
// Zero latency, no handshake; the caller guarantees x_i < 2P.
module p251_reduce #(
  parameter int P     = 251,
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   x_i,
  output logic [WIDTH-1:0] y_o
);

  localparam logic [WIDTH:0] PW = (WIDTH+1)'(P);

  assign y_o = (x_i >= PW) ? WIDTH'(x_i - PW) : x_i[WIDTH-1:0];

endmodule

// File: rtl/p251_add_sub.sv
// Pipelined (a +/- b) mod P; o_done/out exactly 2 cycles after i_start, one op per clock, no backpressure.
// P251_ADD_SUB_OUT_ZERO_EN: when defined, out reads 0 in every cycle o_done is low.
module p251_add_sub
  import p251_pkg::*;
#(
  parameter int P     = P251,
  parameter int WIDTH = p251_pkg::WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_add_sub,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic [WIDTH-1:0] out,
  output logic             o_done
);

  logic [WIDTH-1:0] a_red, b_red;
  logic [WIDTH-1:0] a_q, b_q;
  logic             add_q, vld_q;
  logic [WIDTH:0]   addend, sum;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] out_d, out_q;
  logic             done_d, done_q;

  p251_reduce #(.P(P), .WIDTH(WIDTH)) u_red_a (.x_i({1'b0, in_1}), .y_o(a_red));
  p251_reduce #(.P(P), .WIDTH(WIDTH)) u_red_b (.x_i({1'b0, in_2}), .y_o(b_red));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      add_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= i_start;
      if (i_start) begin
        a_q   <= a_red;
        b_q   <= b_red;
        add_q <= i_add_sub;
      end
    end
  end

  // Subtract is a + (P - b): sum stays within 0..2P-1, so one reducer covers both ops.
  always_comb begin
    addend = add_q ? {1'b0, b_q} : ((WIDTH+1)'(P) - {1'b0, b_q});
    sum    = {1'b0, a_q} + addend;
  end

  p251_reduce #(.P(P), .WIDTH(WIDTH)) u_red_sum (.x_i(sum), .y_o(res));

  always_comb begin
    out_d  = vld_q ? res : out_q;
    done_d = vld_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  assign o_done = done_q;

`ifdef P251_ADD_SUB_OUT_ZERO_EN
  assign out = done_q ? out_q : '0;
`else
  assign out = out_q;
`endif

endmodule

// File: tb/tb_p251_add_sub.sv
// Directed self-checking bench for p251_add_sub.
module tb_p251_add_sub;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       i_add_sub;
  logic [7:0] in_1, in_2;
  logic [7:0] out;
  logic       o_done;

  int asserts  = 0;
  int failures = 0;

  logic       s_add [8];
  logic [7:0] s_a   [8];
  logic [7:0] s_b   [8];
  logic [7:0] s_exp [8];

  always #5 i_clk = ~i_clk;

  p251_add_sub dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_add_sub(i_add_sub),
    .in_1     (in_1),
    .in_2     (in_2),
    .out      (out),
    .o_done   (o_done)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue s_*[0..n-1] back to back; result k must appear on the 2nd edge after its start.
  task automatic stream(input string name, input int n);
    for (int i = 0; i <= n; i++) begin
      i_start = (i < n);
      if (i < n) begin
        i_add_sub = s_add[i];
        in_1      = s_a[i];
        in_2      = s_b[i];
      end
      tick();
      if (i >= 1) begin
        asserts++;
        if (o_done !== 1'b1 || out !== s_exp[i-1]) begin
          failures++;
          $display("FAIL %s[%0d]: got done=%b out=%0d, want done=1 out=%0d",
                   name, i-1, o_done, out, s_exp[i-1]);
        end
      end
    end
    tick();
    asserts++;
    if (o_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: got done=%b, want done=0", name, o_done);
    end
  endtask

  task automatic test_reset();
    asserts++;
    if (out !== 8'd0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got done=%b out=%0d, want done=0 out=0", o_done, out);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_sweep();
    int exp_v;
    for (int i = 0; i <= 256; i++) begin
      i_start   = (i < 256);
      i_add_sub = 1'b1;
      in_1      = 8'(i);
      in_2      = 8'd250;
      tick();
      if (i >= 1) begin
        exp_v = (i - 1 + 250) % 251;
        asserts++;
        if (o_done !== 1'b1 || out !== 8'(exp_v)) begin
          failures++;
          $display("FAIL sweep[%0d]: got done=%b out=%0d, want done=1 out=%0d",
                   i-1, o_done, out, exp_v);
        end
      end
    end
    tick();
    asserts++;
    if (o_done !== 1'b0) begin
      failures++;
      $display("FAIL sweep_drain: got done=%b, want done=0", o_done);
    end
  endtask

  task automatic test_back_to_back();
    s_add = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    s_a   = '{8'd1, 8'd2, 8'd3, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0};
    s_b   = '{8'd20, 8'd31, 8'd85, 8'd165, 8'd0, 8'd0, 8'd0, 8'd0};
    s_exp = '{8'd21, 8'd33, 8'd88, 8'd171, 8'd0, 8'd0, 8'd0, 8'd0};
    stream("b2b_add", 4);
  endtask

  task automatic test_sub();
    s_add = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    s_a   = '{8'd1, 8'd6, 8'd0, 8'd100, 8'd255, 8'd0, 8'd250, 8'd251};
    s_b   = '{8'd20, 8'd165, 8'd250, 8'd100, 8'd251, 8'd255, 8'd0, 8'd251};
    s_exp = '{8'd232, 8'd92, 8'd1, 8'd0, 8'd4, 8'd247, 8'd250, 8'd0};
    stream("sub", 8);
  endtask

  task automatic test_extremes();
    s_add = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    s_a   = '{8'd250, 8'd251, 8'd255, 8'd250, 8'd0, 8'd0, 8'd1, 8'd0};
    s_b   = '{8'd250, 8'd251, 8'd255, 8'd250, 8'd0, 8'd1, 8'd250, 8'd0};
    s_exp = '{8'd249, 8'd0, 8'd8, 8'd0, 8'd0, 8'd250, 8'd0, 8'd0};
    stream("extreme", 8);
  endtask

  task automatic test_reset_inflight();
    i_start = 1'b1; i_add_sub = 1'b1; in_1 = 8'd100; in_2 = 8'd50;
    tick();
    i_add_sub = 1'b0; in_1 = 8'd9; in_2 = 8'd3;
    tick();
    i_start = 1'b0;
    asserts++;
    if (o_done !== 1'b1 || out !== 8'd150) begin
      failures++;
      $display("FAIL pre_reset: got done=%b out=%0d, want done=1 out=150", o_done, out);
    end
    #2;
    i_rst = 1'b1;
    #1;
    asserts++;
    if (o_done !== 1'b0 || out !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: got done=%b out=%0d, want done=0 out=0", o_done, out);
    end
    tick();
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++;
      if (o_done !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_done[%0d]: got done=%b, want done=0", i, o_done);
      end
    end
    s_add[0] = 1'b1; s_a[0] = 8'd7; s_b[0] = 8'd8; s_exp[0] = 8'd15;
    stream("after_reset", 1);
  endtask

  task automatic test_idle();
    int   pulses;
    logic [7:0] hold_exp;
`ifdef P251_ADD_SUB_OUT_ZERO_EN
    hold_exp = 8'd0;
`else
    hold_exp = 8'd49;
`endif
    pulses = 0;
    i_start = 1'b1; i_add_sub = 1'b1; in_1 = 8'd200; in_2 = 8'd100;
    tick();
    i_start = 1'b0; in_1 = 8'd5; in_2 = 8'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_done === 1'b1) begin
        pulses++;
        asserts++;
        if (out !== 8'd49) begin
          failures++;
          $display("FAIL idle_result: got out=%0d, want out=49", out);
        end
      end
    end
    asserts++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL idle_pulses: got %0d done pulses, want 1", pulses);
    end
    asserts++;
    if (out !== hold_exp) begin
      failures++;
      $display("FAIL idle_hold: got out=%0d, want out=%0d", out, hold_exp);
    end
  endtask

  initial begin
    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_add_sub = 1'b0;
    in_1      = 8'd0;
    in_2      = 8'd0;
    #12;
    test_reset();
    tick();
    test_sweep();
    test_back_to_back();
    test_sub();
    test_extremes();
    test_reset_inflight();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
